// File: rtl/btn_debounce_sched.sv
// NB-button debouncer that time-shares one N-bit window timer, granted round-robin.
// Define BTN_DEBOUNCE_SCHED_REL_TICK_EN to add the rel_tick release-pulse output.
module btn_debounce_sched #(
  parameter int NB = 4,
  parameter int N  = 21,
  localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] sw,
  output logic [NB-1:0] db_level,
  output logic [NB-1:0] db_tick,
  output logic          busy,
  output logic [IW-1:0] gnt_idx
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
  ,
  output logic [NB-1:0] rel_tick
`endif
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t        state_r, state_n;
  logic [NB-1:0] sync1_r, sw_s;
  logic [N-1:0]  timer_r, timer_n;
  logic [IW-1:0] rr_ptr_r, rr_ptr_n;
  logic [IW-1:0] gnt_n;
  logic [NB-1:0] lvl_n, tick_n;
  logic [NB-1:0] pending_s;
  logic [IW-1:0] pick_s;
  logic          found_s;
  int            cand_s;
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
  logic [NB-1:0] rel_n;
`endif

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    if (int'(i) == NB - 1) begin
      return '0;
    end else begin
      return i + IW'(1);
    end
  endfunction

  assign pending_s = sw_s ^ db_level;
  assign busy      = (state_r == COUNT);

  // Two-flop synchronizer on the raw button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sw_s    <= '0;
    end else begin
      sync1_r <= sw;
      sw_s    <= sync1_r;
    end
  end

  // First pending button at or after rr_ptr, wrapping modulo NB
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = 0;
    for (int k = 0; k < NB; k++) begin
      cand_s = (int'(rr_ptr_r) + k) % NB;
      if (!found_s && pending_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Scheduler next-state: grant, count, abort on bounce-back, commit at terminal count
  always_comb begin
    state_n  = state_r;
    timer_n  = timer_r;
    rr_ptr_n = rr_ptr_r;
    gnt_n    = gnt_idx;
    lvl_n    = db_level;
    tick_n   = '0;
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
    rel_n    = '0;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = COUNT;
          timer_n = '0;
          gnt_n   = pick_s;
        end else begin
          state_n = IDLE;
        end
      end
      COUNT: begin
        if (sw_s[gnt_idx] == db_level[gnt_idx]) begin
          state_n  = IDLE;
          rr_ptr_n = inc_idx(gnt_idx);
        end else if (timer_r != '1) begin
          timer_n = timer_r + N'(1);
        end else begin
          state_n          = IDLE;
          rr_ptr_n         = inc_idx(gnt_idx);
          lvl_n[gnt_idx]   = ~db_level[gnt_idx];
          tick_n[gnt_idx]  = ~db_level[gnt_idx];
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
          rel_n[gnt_idx]   = db_level[gnt_idx];
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Scheduler and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      rr_ptr_r <= '0;
      gnt_idx  <= '0;
      db_level <= '0;
      db_tick  <= '0;
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
      rel_tick <= '0;
`endif
    end else begin
      state_r  <= state_n;
      timer_r  <= timer_n;
      rr_ptr_r <= rr_ptr_n;
      gnt_idx  <= gnt_n;
      db_level <= lvl_n;
      db_tick  <= tick_n;
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
      rel_tick <= rel_n;
`endif
    end
  end

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Scoreboard bench for btn_debounce_sched (N=4, NB=4): stimulus queues expected
// grants/commits with absolute edge numbers, a negedge monitor pops and compares.
module tb_btn_debounce_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] db_level;
  logic [3:0] db_tick;
  logic       busy;
  logic [1:0] gnt_idx;
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
  logic [3:0] rel_tick;
`endif

  btn_debounce_sched #(.NB(4), .N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick),
    .busy     (busy),
    .gnt_idx  (gnt_idx)
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
    ,
    .rel_tick (rel_tick)
`endif
  );

  typedef struct {int idx; int start; int stop;} gnt_t;
  typedef struct {int lvl; int tick; int rel; int at;} ev_t;

  gnt_t gnt_q[$];
  ev_t  exp_q[$];
  gnt_t cur;
  bit   cur_v = 1'b0;
  int   ecnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
  endtask

  task automatic push_g(input int idx, input int start, input int stop);
    gnt_t g;
    g.idx = idx; g.start = start; g.stop = stop;
    gnt_q.push_back(g);
  endtask

  task automatic push_e(input int lvl, input int tick, input int rel, input int at);
    ev_t e;
    e.lvl = lvl; e.tick = tick; e.rel = rel; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0 || cur_v) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_outstanding", exp_q.size() + gnt_q.size() + int'(cur_v), 0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: grants on busy rise/fall, commits on level change or tick
  initial begin
    logic [3:0] prev_level;
    logic       prev_busy;
    logic       ev_s;
    gnt_t       g;
    ev_t        e;
    prev_level = '0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_level = '0;
        prev_busy  = 1'b0;
        cur_v      = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          if (gnt_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_grant: got gnt_idx=%0d at edge %0d expected none", gnt_idx, ecnt);
          end else begin
            g = gnt_q.pop_front();
            chk("gnt_idx", int'(gnt_idx), g.idx);
            chk("gnt_edge", ecnt, g.start);
            cur   = g;
            cur_v = 1'b1;
          end
        end
        if (!busy && prev_busy && cur_v) begin
          chk("busy_fall_edge", ecnt, cur.stop);
          cur_v = 1'b0;
        end
        ev_s = (db_level != prev_level) || (db_tick != 4'b0000);
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
        ev_s = ev_s || (rel_tick != 4'b0000);
`endif
        if (ev_s) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_commit: got level=%b tick=%b at edge %0d expected none", db_level, db_tick, ecnt);
          end else begin
            e = exp_q.pop_front();
            chk("commit_level", int'(db_level), e.lvl);
            chk("commit_tick", int'(db_tick), e.tick);
            chk("commit_edge", ecnt, e.at);
`ifdef BTN_DEBOUNCE_SCHED_REL_TICK_EN
            chk("commit_rel_tick", int'(rel_tick), e.rel);
`endif
          end
        end
        prev_level = db_level;
        prev_busy  = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int e;
    rst_n = 1'b0;
    sw    = 4'b0000;
    #1;
    chk("reset_level", int'(db_level), 0);
    chk("reset_tick", int'(db_tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_gnt", int'(gnt_idx), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // two simultaneous presses: button 0 then button 2
    @(negedge clk); sw = 4'b0101; e = ecnt;
    push_g(0, e + 3, e + 19); push_g(2, e + 20, e + 36);
    push_e(4'b0001, 4'b0001, 4'b0000, e + 19);
    push_e(4'b0101, 4'b0100, 4'b0000, e + 36);
    wait_done(100);

    // release both: rr_ptr=3 wraps to button 0 first
    @(negedge clk); sw = 4'b0000; e = ecnt;
    push_g(0, e + 3, e + 19); push_g(2, e + 20, e + 36);
    push_e(4'b0100, 4'b0000, 4'b0001, e + 19);
    push_e(4'b0000, 4'b0000, 4'b0100, e + 36);
    wait_done(100);

    // 8-cycle glitch on button 0 aborts the window
    @(negedge clk); sw = 4'b0001; e = ecnt;
    push_g(0, e + 3, e + 11);
    repeat (8) @(negedge clk);
    sw = 4'b0000;
    wait_done(100);
    chk("abort_level", int'(db_level), 0);

    // isolated clean press
    @(negedge clk); sw = 4'b0001; e = ecnt;
    push_g(0, e + 3, e + 19);
    push_e(4'b0001, 4'b0001, 4'b0000, e + 19);
    wait_done(100);

    // reset mid-window on button 1 (timer=9), then fresh windows
    @(negedge clk); sw = 4'b0011; e = ecnt;
    push_g(1, e + 3, 0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", int'(db_level), 0);
    chk("midrst_tick", int'(db_tick), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_gnt", int'(gnt_idx), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1; e = ecnt;
    push_g(0, e + 3, e + 19); push_g(1, e + 20, e + 36);
    push_e(4'b0001, 4'b0001, 4'b0000, e + 19);
    push_e(4'b0011, 4'b0010, 4'b0000, e + 36);
    wait_done(100);

    // all four change at once: order 2,3,0,1 from rr_ptr=2
    @(negedge clk); sw = 4'b1100; e = ecnt;
    push_g(2, e + 3, e + 19); push_g(3, e + 20, e + 36);
    push_g(0, e + 37, e + 53); push_g(1, e + 54, e + 70);
    push_e(4'b0111, 4'b0100, 4'b0000, e + 19);
    push_e(4'b1111, 4'b1000, 4'b0000, e + 36);
    push_e(4'b1110, 4'b0000, 4'b0001, e + 53);
    push_e(4'b1100, 4'b0000, 4'b0010, e + 70);
    wait_done(150);

    // and all four back again
    @(negedge clk); sw = 4'b0011; e = ecnt;
    push_g(2, e + 3, e + 19); push_g(3, e + 20, e + 36);
    push_g(0, e + 37, e + 53); push_g(1, e + 54, e + 70);
    push_e(4'b1000, 4'b0000, 4'b0100, e + 19);
    push_e(4'b0000, 4'b0000, 4'b1000, e + 36);
    push_e(4'b0001, 4'b0001, 4'b0000, e + 53);
    push_e(4'b0011, 4'b0010, 4'b0000, e + 70);
    wait_done(150);

    chk("final_level", int'(db_level), 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_debounce_sched.md
BTN_DEBOUNCE_SCHED -- requirements
Module: btn_debounce_sched

Interface
REQ-001 Parameter NB, default 4: number of buttons sharing one debounce timer.
REQ-002 Parameter N, default 21: timer width; debounce window is 2^N clocks (42 ms at 50 MHz).
REQ-003 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sw  input  NB  raw, asynchronous button inputs.
REQ-006 db_level  output  NB  debounced stable level per button.
REQ-007 db_tick  output  NB  one-clock pulse per button on a debounced 0->1 transition.
REQ-008 busy  output  1  high while the shared timer is granted to a button.
REQ-009 gnt_idx  output  clog2(NB)  index of the button owning the timer, valid while busy.

Function
REQ-010 Each sw bit SHALL pass through a 2-flop synchronizer; sw_s denotes the second-stage output.
REQ-011 pending[i] SHALL be defined as sw_s[i] XOR db_level[i].
- States: IDLE, COUNT. busy SHALL be 1 exactly in COUNT.
REQ-012 In IDLE with pending != 0, the block SHALL grant the first pending index at or after rr_ptr (wrapping modulo NB), load timer=0, set gnt_idx and enter COUNT on that edge.
REQ-013 In IDLE with pending == 0, the block SHALL hold state, timer and rr_ptr.
REQ-014 In COUNT with sw_s[gnt_idx] == db_level[gnt_idx] (bounce back), the block SHALL abort: return to IDLE, leave db_level unchanged, set rr_ptr = gnt_idx+1 mod NB, and emit no tick.
REQ-015 In COUNT with the input still differing and timer < 2^N-1, the timer SHALL increment by 1.
REQ-016 In COUNT with the input still differing and timer == 2^N-1, on that edge the block SHALL toggle db_level[gnt_idx], set rr_ptr = gnt_idx+1 mod NB, and return to IDLE. The timer SHALL NOT wrap inside COUNT.
REQ-017 db_tick[gnt_idx] SHALL be registered and high for exactly the one cycle following the commit edge, only if the new level is 1; all other db_tick bits SHALL be 0.
- Latency: an isolated clean edge on sw[i] updates db_level[i] on the (2^N+3)th rising clk edge after the change.
REQ-018 Non-granted buttons SHALL keep their db_level while another button is timed; their pending state is served in round-robin order afterwards.
- With all NB pending, each is granted within NB windows, so there is no starvation.
REQ-019 At most one db_level bit SHALL change per clock.

Reset
REQ-020 rst_n low SHALL asynchronously clear the synchronizers, db_level, db_tick, busy, gnt_idx, timer and rr_ptr to 0, and set state to IDLE.
REQ-021 Reset asserted during COUNT SHALL discard the in-progress window with no tick; after release, debouncing restarts from IDLE.

Configuration
REQ-022 Macro BTN_DEBOUNCE_SCHED_REL_TICK_EN:
- Defined: adds output rel_tick [NB], a one-cycle pulse on debounced 1->0 commits, with the same timing as db_tick.
- Undefined: no rel_tick port, and releases produce no pulse.

Verification (N=4, NB=4)
REQ-023 sw=0001 held from cycle 0 -> db_level[0]=1 and db_tick=0001 at edge 19 (tick for one cycle); busy high for 16 cycles.
REQ-024 sw[0] high for 8 cycles then low -> abort: busy drops, db_level stays 0000, no tick.
REQ-025 sw=0101 asserted simultaneously -> button 0 committed at edge 19; button 2 granted at the next IDLE edge and committed 17 edges later; gnt_idx shows 0, then 2.
REQ-026 db_level=0001, then sw=0000 -> db_level[0] clears at edge 19 with db_tick=0; with the macro defined, rel_tick[0] pulses instead.
REQ-027 rst_n pulsed low mid-COUNT (timer=9) -> all outputs 0 immediately; with sw held, a fresh full 2^N window elapses before commit.
REQ-028 All four buttons toggled continuously -> db_tick never has more than one bit set, and grant order follows round-robin 0,1,2,3.
